// File: rtl/dom_gf16_inverter_pkg.sv
// GF(2^2) normal-basis arithmetic shared by the masked GF(2^4) inverter
// and its DOM multiplier.
package dom_gf16_inverter_pkg;

  localparam int GF16_W   = 4;
  localparam int GF4_W    = 2;
  localparam int LAT_BASE = 2;

  localparam logic [GF4_W-1:0] GF4_ZERO = 2'b00;
  localparam logic [GF4_W-1:0] GF4_ONE  = 2'b11;

  // Bilinear over GF(2), so it distributes across Boolean shares.
  function automatic logic [GF4_W-1:0] gf4_mul(input logic [GF4_W-1:0] a,
                                              input logic [GF4_W-1:0] b);
    logic t;
    t = (a[1] ^ a[0]) & (b[1] ^ b[0]);
    return {(a[1] & b[1]) ^ t, (a[0] & b[0]) ^ t};
  endfunction

  function automatic logic [GF4_W-1:0] gf4_sq_scl(input logic [GF4_W-1:0] i);
    return {i[1] ^ i[0], i[0]};
  endfunction

  function automatic logic [GF4_W-1:0] gf4_inv(input logic [GF4_W-1:0] i);
    return {i[0], i[1]};
  endfunction

endpackage

// File: rtl/dom_gf16_inverter_mul.sv
// Two-share DOM-indep GF(2^2) multiplier: inner and masked cross terms are
// registered, and the shares are recombined only after those registers.
module dom_gf4_mul
  import dom_gf16_inverter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [GF4_W-1:0] a_a,
  input  logic [GF4_W-1:0] a_b,
  input  logic [GF4_W-1:0] b_a,
  input  logic [GF4_W-1:0] b_b,
  input  logic [GF4_W-1:0] z,
  output logic [GF4_W-1:0] out_a,
  output logic [GF4_W-1:0] out_b
);

  logic [GF4_W-1:0] inner_a_q;
  logic [GF4_W-1:0] inner_b_q;
  logic [GF4_W-1:0] cross_ab_q;
  logic [GF4_W-1:0] cross_ba_q;

  // The same fresh mask z hides both cross terms; it cancels when the two
  // output shares are recombined downstream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inner_a_q  <= GF4_ZERO;
      inner_b_q  <= GF4_ZERO;
      cross_ab_q <= GF4_ZERO;
      cross_ba_q <= GF4_ZERO;
    end else begin
      inner_a_q  <= gf4_mul(a_a, b_a);
      inner_b_q  <= gf4_mul(a_b, b_b);
      cross_ab_q <= gf4_mul(a_a, b_b) ^ z;
      cross_ba_q <= gf4_mul(a_b, b_a) ^ z;
    end
  end

  assign out_a = inner_a_q ^ cross_ab_q;
  assign out_b = inner_b_q ^ cross_ba_q;

endmodule

// File: rtl/dom_gf16_inverter.sv
// Two-share DOM GF(2^4) inverter, 2-stage pipeline (3 with OUT_REG=1).
// in_valid/out_valid are pure qualifiers: no ready, no backpressure; an item is accepted on every rising edge where in_valid=1 and rst_n=1.
module dom_gf16_inverter
  import dom_gf16_inverter_pkg::*;
#(
  parameter int OUT_REG = 0
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [GF16_W-1:0] in_a,
  input  logic [GF16_W-1:0] in_b,
  input  logic [GF4_W-1:0]  rand1,
  input  logic [GF4_W-1:0]  rand2,
  input  logic [GF4_W-1:0]  rand3,
  output logic              out_valid,
  output logic [GF16_W-1:0] out_a,
  output logic [GF16_W-1:0] out_b
);

  logic [GF4_W-1:0] xh_a, xl_a, xh_b, xl_b;
  logic [GF4_W-1:0] sq_a_q, sq_b_q;
  logic [GF4_W-1:0] xh_a_q, xl_a_q, xh_b_q, xl_b_q;
  logic [GF4_W-1:0] m1_a, m1_b, m2_a, m2_b, m3_a, m3_b;
  logic [GF4_W-1:0] theta_a, theta_b, ti_a, ti_b;
  logic [GF16_W-1:0] res_a, res_b;
  logic [LAT_BASE-1:0] vld_q;

  assign xh_a = in_a[3:2];
  assign xl_a = in_a[1:0];
  assign xh_b = in_b[3:2];
  assign xl_b = in_b[1:0];

  // Stage 1: M1 = xh*xl, plus per-domain square-scaled sums and operand copies.
  dom_gf4_mul u_m1 (
    .clk   (clk),
    .rst_n (rst_n),
    .a_a   (xh_a),
    .a_b   (xh_b),
    .b_a   (xl_a),
    .b_b   (xl_b),
    .z     (rand1),
    .out_a (m1_a),
    .out_b (m1_b)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sq_a_q <= GF4_ZERO;
      sq_b_q <= GF4_ZERO;
      xh_a_q <= GF4_ZERO;
      xl_a_q <= GF4_ZERO;
      xh_b_q <= GF4_ZERO;
      xl_b_q <= GF4_ZERO;
      vld_q  <= '0;
    end else begin
      sq_a_q <= gf4_sq_scl(xh_a ^ xl_a);
      sq_b_q <= gf4_sq_scl(xh_b ^ xl_b);
      xh_a_q <= xh_a;
      xl_a_q <= xl_a;
      xh_b_q <= xh_b;
      xl_b_q <= xl_b;
      vld_q  <= {vld_q[0], in_valid};
    end
  end

  // Sq-scaler and inversion are linear, so each domain handles its own share.
  assign theta_a = m1_a ^ sq_a_q;
  assign theta_b = m1_b ^ sq_b_q;
  assign ti_a    = gf4_inv(theta_a);
  assign ti_b    = gf4_inv(theta_b);

  // Stage 2: rand2/rand3 arrive one cycle after the item, aligned with R2 load.
  dom_gf4_mul u_m2 (
    .clk   (clk),
    .rst_n (rst_n),
    .a_a   (ti_a),
    .a_b   (ti_b),
    .b_a   (xl_a_q),
    .b_b   (xl_b_q),
    .z     (rand2),
    .out_a (m2_a),
    .out_b (m2_b)
  );

  dom_gf4_mul u_m3 (
    .clk   (clk),
    .rst_n (rst_n),
    .a_a   (ti_a),
    .a_b   (ti_b),
    .b_a   (xh_a_q),
    .b_b   (xh_b_q),
    .z     (rand3),
    .out_a (m3_a),
    .out_b (m3_b)
  );

  assign res_a = {m2_a, m3_a};
  assign res_b = {m2_b, m3_b};

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [GF16_W-1:0] r3_a_q, r3_b_q;
      logic              r3_vld_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r3_a_q   <= '0;
          r3_b_q   <= '0;
          r3_vld_q <= 1'b0;
        end else begin
          r3_a_q   <= res_a;
          r3_b_q   <= res_b;
          r3_vld_q <= vld_q[LAT_BASE-1];
        end
      end

      assign out_a     = r3_a_q;
      assign out_b     = r3_b_q;
      assign out_valid = r3_vld_q;
    end else begin : g_no_out_reg
      assign out_a     = res_a;
      assign out_b     = res_b;
      assign out_valid = vld_q[LAT_BASE-1];
    end
  endgenerate

endmodule

// File: tb/tb_dom_gf16_inverter.sv
// Bench for dom_gf16_inverter: drives the OUT_REG=0 and OUT_REG=1 builds
// side by side and scoreboards both against hand-computed inverses.
module tb_dom_gf16_inverter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_a = '0, in_b = '0;
  logic [1:0] rand1 = '0, rand2 = '0, rand3 = '0;
  logic       ov0, ov1;
  logic [3:0] oa0, ob0, oa1, ob1;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];
  int         exp_cyc_q[$];
  logic [3:0] exp_r_q[$];
  int         exp_r_cyc_q[$];

  logic [3:0] e0, e1, ed;
  int         c0, c1, cd;

  // Inverse table worked out by hand from the unmasked tower-field formula.
  logic [3:0] inv_tab [16] = '{4'h0, 4'h4, 4'hC, 4'h8, 4'h1, 4'hA, 4'hE, 4'hD,
                               4'h3, 4'hB, 4'h5, 4'h9, 4'h2, 4'h7, 4'h6, 4'hF};

  dom_gf16_inverter #(.OUT_REG(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .rand1(rand1), .rand2(rand2), .rand3(rand3),
    .out_valid(ov0), .out_a(oa0), .out_b(ob0)
  );

  dom_gf16_inverter #(.OUT_REG(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .rand1(rand1), .rand2(rand2), .rand3(rand3),
    .out_valid(ov1), .out_a(oa1), .out_b(ob1)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (ov0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out0_unexpected: cycle %0d got %b want no valid", cyc, oa0 ^ ob0);
      end else begin
        e0 = exp_q.pop_front();
        c0 = exp_cyc_q.pop_front();
        if ((oa0 ^ ob0) !== e0 || cyc != c0) begin
          errors++;
          $display("FAIL out0_data: cycle %0d got %b, want %b at cycle %0d", cyc, oa0 ^ ob0, e0, c0);
        end
      end
    end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
      checks++;
      errors++;
      e0 = exp_q.pop_front();
      c0 = exp_cyc_q.pop_front();
      $display("FAIL out0_missing: cycle %0d got no valid, want %b", cyc, e0);
    end
  end

  always @(negedge clk) begin
    if (ov1) begin
      checks++;
      if (exp_r_q.size() == 0) begin
        errors++;
        $display("FAIL out1_unexpected: cycle %0d got %b want no valid", cyc, oa1 ^ ob1);
      end else begin
        e1 = exp_r_q.pop_front();
        c1 = exp_r_cyc_q.pop_front();
        if ((oa1 ^ ob1) !== e1 || cyc != c1) begin
          errors++;
          $display("FAIL out1_data: cycle %0d got %b, want %b at cycle %0d", cyc, oa1 ^ ob1, e1, c1);
        end
      end
    end else if (exp_r_cyc_q.size() > 0 && exp_r_cyc_q[0] <= cyc) begin
      checks++;
      errors++;
      e1 = exp_r_q.pop_front();
      c1 = exp_r_cyc_q.pop_front();
      $display("FAIL out1_missing: cycle %0d got no valid, want %b", cyc, e1);
    end
  end

  // ---------------- driver tasks ----------------
  // r2/r3 given here belong to the item driven in the previous call.
  task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b,
                      input logic [1:0] r1, input logic [1:0] r2, input logic [1:0] r3,
                      input logic [3:0] e);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    rand1    = r1;
    rand2    = r2;
    rand3    = r3;
    if (v && rst_n) begin
      exp_q.push_back(e);
      exp_cyc_q.push_back(cyc + 2);
      exp_r_q.push_back(e);
      exp_r_cyc_q.push_back(cyc + 3);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_step(input logic v, input logic [3:0] x, input logic [3:0] e);
    logic [3:0] b;
    b = 4'($urandom_range(0, 15));
    step(v, x ^ b, b, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
         2'($urandom_range(0, 3)), e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) rnd_step(1'b0, 4'($urandom_range(0, 15)), 4'h0);
  endtask

  task automatic expect_eq(input string name, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic expect_zero_outputs(input string tag);
    expect_eq({tag, "_valid0"}, {3'b000, ov0}, 4'h0);
    expect_eq({tag, "_a0"}, oa0, 4'h0);
    expect_eq({tag, "_b0"}, ob0, 4'h0);
    expect_eq({tag, "_valid1"}, {3'b000, ov1}, 4'h0);
    expect_eq({tag, "_a1"}, oa1, 4'h0);
    expect_eq({tag, "_b1"}, ob1, 4'h0);
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] b2b_x [3] = '{4'b0100, 4'b0001, 4'b0000};
  logic [3:0] b2b_e [3] = '{4'b0001, 4'b0100, 4'b0000};

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    expect_zero_outputs("reset");
    rst_n = 1'b1;
    in_valid = 1'b0;

    // x = 1111 with all-zero randomness
    step(1'b1, 4'b1111, 4'b0000, 2'b00, 2'b00, 2'b00, 4'b1111);
    step(1'b0, 4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 4'h0);
    idle(4);

    // x = 0101 -> 1010, then x = 1010 -> 0101, explicit masks
    step(1'b1, 4'b0110, 4'b0011, 2'b10, 2'b00, 2'b00, 4'b1010);
    step(1'b1, 4'b1100, 4'b0110, 2'b01, 2'b01, 2'b11, 4'b0101);
    step(1'b0, 4'b0000, 4'b0000, 2'b00, 2'b10, 2'b01, 4'h0);
    idle(4);

    // back-to-back stream
    for (int i = 0; i < 3; i++) rnd_step(1'b1, b2b_x[i], b2b_e[i]);
    idle(5);

    // all x values, 8 random share splits each, streamed
    for (int x = 0; x < 16; x++)
      for (int s = 0; s < 8; s++) rnd_step(1'b1, 4'(x), inv_tab[x]);
    // inverse of inverse returns the original
    for (int x = 0; x < 16; x++) rnd_step(1'b1, inv_tab[x], 4'(x));
    idle(5);

    // reset while items are in flight; in_valid during reset ignored
    rnd_step(1'b1, 4'b0101, 4'b1010);
    rst_n = 1'b0;
    while (exp_cyc_q.size() > 0 && exp_cyc_q[$] > cyc) begin
      ed = exp_q.pop_back();
      cd = exp_cyc_q.pop_back();
    end
    while (exp_r_cyc_q.size() > 0 && exp_r_cyc_q[$] > cyc) begin
      ed = exp_r_q.pop_back();
      cd = exp_r_cyc_q.pop_back();
    end
    rnd_step(1'b1, 4'b0111, 4'b1101);
    rst_n = 1'b1;
    expect_zero_outputs("midreset");
    rnd_step(1'b1, 4'b1010, 4'b0101);
    idle(6);

    checks++;
    if (exp_q.size() != 0 || exp_r_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending items, want 0/0", exp_q.size(), exp_r_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at cycle %0d, want completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dom_gf16_inverter.md
Name: dom_gf16_inverter

Overview:
- Two-share, domain-oriented-masked (DOM) GF(2^4) inverter. Forms the core of the masked tower-field AES S-box.
- Upstream: the GF(2^8)->GF(2^4) reduction stage.
- Downstream: the GF(2^4) masked multipliers that finish the GF(2^8) inversion.
- Internally uses the GF(2^2) square-scaler and DOM-indep GF(2^2) multipliers, with register stages after every nonlinear layer.
- Fully pipelined; accepts one new input every cycle.

Parameters:
OUT_REG, 0, 1 = add an extra output register stage (latency 3 instead of 2)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  reset
in_valid  in  1  input shares valid this cycle
in_a  in  4  share A of operand x, {xh[1:0], xl[1:0]}, normal basis
in_b  in  4  share B of operand x; x = in_a ^ in_b
rand1  in  2  fresh mask for multiplier M1; sampled in the in_valid cycle
rand2  in  2  fresh mask for multiplier M2; sampled one cycle after in_valid
rand3  in  2  fresh mask for multiplier M3; sampled one cycle after in_valid
out_valid  out  1  output shares valid
out_a  out  4  share A of x^-1
out_b  out  4  share B of x^-1

Interface decision: one clock; reset is synchronous and active-low.

Behaviour:
- Arithmetic is in GF(2^2), normal basis.
  - Square-scaler: sq(i) = {i[1]^i[0], i[0]}.
  - Mul(a,b): t=(a1^a0)&(b1^b0); out1=(a1&b1)^t; out0=(a0&b0)^t.
  - Inverse in GF(2^2) is a bit swap {i[0], i[1]}.
- Unmasked function:
  - theta = sq(xh^xl) ^ Mul(xh,xl)
  - ti = swap(theta)
  - result = {Mul(ti,xl), Mul(ti,xh)}
  - 0 maps to 0.
- Stage 1 (register bank R1, loaded every cycle):
  - M1 = DOM-indep Mul(xh,xl) per share.
  - Inner terms Mul(xh_A,xl_A) and Mul(xh_B,xl_B) are registered.
  - Cross terms Mul(xh_A,xl_B)^rand1 and Mul(xh_B,xl_A)^rand1 are registered.
  - sq((xh^xl)_A) goes into domain A only; sq((xh^xl)_B) into domain B only, both registered.
  - xh and xl shares of both domains are registered.
- Stage 1 compression (combinational after R1):
  - theta_A = inner_A ^ crossAB ^ sqA
  - theta_B = inner_B ^ crossBA ^ sqB
  - ti_X = swap(theta_X) for each domain.
- Stage 2 (register bank R2):
  - M2 = DOM-indep Mul(ti, xl) with rand2.
  - M3 = DOM-indep Mul(ti, xh) with rand3.
  - Inner and cross terms are registered.
  - Compression after R2 gives out_a = {M2_A, M3_A} and out_b = {M2_B, M3_B}.
- With OUT_REG=1 the compressed outputs pass through R3.
- Latency: in_valid at cycle n gives out_valid at n+2 (n+3 with OUT_REG=1). Throughput is 1 per cycle.
- out_valid is a shift of in_valid through 2 (or 3) flops.
- Data registers load unconditionally. Outputs carry don't-care values when out_valid=0, but must be deterministic functions of the inputs.
- Domain separation:
  - No combinational path may combine A and B share signals except through a registered, rand-masked cross term.
  - Compression XORs only registered signals.
- Reset (rst_n=0 at a rising edge):
  - All R1/R2/R3 flops and the valid pipeline clear to 0.
  - out_valid=0, out_a=0, out_b=0 on the following cycle.
- Reset mid-operation: in-flight items are discarded. No out_valid pulse for any input accepted in the two cycles before reset.
- in_valid asserted during reset is ignored.
- Back-to-back in_valid produces back-to-back out_valid, in order. Stage-2 randomness must belong to the correct item (rand2/rand3 at cycle n+1 pair with the item entered at n).
- Randomness of all zero still yields a functionally correct result; only masking security is lost.

Decomposition:
- Shared package holds:
  - GF(2^2) constants: ONE = 2'b11 in normal basis, ZERO.
  - Functions gf4_mul, gf4_sq_scl, gf4_inv (swap).
  - GF(2^4) width and latency localparams.
- One natural sub-module: dom_gf4_mul, a 2-share DOM-indep GF(2^2) multiplier.
  - Ports: clk, rst_n, a_A/a_B, b_A/b_B, z; registered cross and inner terms; compressed out_A/out_B.
  - Instantiated three times.
  - The existing square-scaler is reused for sq.

Test Plan:
- Reset then in_a=4'b1111, in_b=0, rand=0, in_valid at cycle 0 -> out_valid at cycle 2 only; out_a^out_b=4'b1111.
- in_a=4'b0110, in_b=4'b0011 (x=0101), rand1=2'b10, rand2=2'b01, rand3=2'b11 -> out_a^out_b=4'b1010; then x=1010 -> 0101.
- Back-to-back x=0100, 0001, 0000 with random shares and random rand each cycle -> consecutive outputs 0001, 0100, 0000 in cycles n+2..n+4.
- Exhaustive sweep: all 16 x values × 8 random share splits × random masks, streamed continuously -> each result matches the reference model; inverse(inverse(x))==x.
- rst_n low for one cycle while two items are in flight -> no out_valid for them; out_a=out_b=0 next cycle; a new item accepted after reset returns at +2.
- OUT_REG=1 build: x=0101 -> out_valid at n+3; result 1010; reset clears R3.
